lcd_pin_decoder: RTL and testbench
==================================

Name: lcd_pin_decoder

Overview:
- Passive receiver for the HD44780-style LCD pin bundle (lcd_pins_t) that our LCD write path drives. It watches rs/rw/e/db on the pins and reconstructs the byte stream the panel would latch.
- It tracks the 8-bit to 4-bit interface mode switch, the entry-mode direction and the DDRAM address.
- Each decoded byte is presented on a val/rdy stream.
- Uses: a synthesizable screen-capture/monitor in simulation, and an on-chip loopback check of the LCD write path.

Parameters:
- NIBBLE_TIMEOUT, 1000000, clocks allowed between high and low nibble falling edges before the half byte is discarded. 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- lcd_pins  input  lcd_pins_t  monitored pins: rw, rs, e, db (4-bit, DB7..DB4)
- val  output  1  decoded byte valid
- rdy  input  1  consumer ready; a transfer occurs when val && rdy
- bits  output  8  decoded byte
- is_cmd  output  1  1 if the byte was written with rs=0 (instruction), 0 for data
- mode4  output  1  decoder is in 4-bit interface mode
- ddram_addr  output  7  tracked DDRAM address after the last applied byte
- overflow  output  1  sticky: a byte was dropped because the output was still occupied
- err  output  1  sticky: rs mismatch between nibbles, or nibble timeout

Behaviour:
- Reset values, all outputs: val=0, bits=0, is_cmd=0, mode4=0, ddram_addr=0, overflow=0, err=0. Internal state: r_e=0, I/D=1, state=MODE8, timeout counter cleared.
- Reset applied mid-byte discards the pending half byte and returns the decoder to MODE8.
- Falling-edge strobe: r_e holds the previous value of e. A strobe occurs in a cycle where r_e=1 && e=0 && rw=0. Edges with rw=1 (read cycles) are ignored entirely. db and rs are sampled in the strobe cycle.
- States:
  - MODE8: each strobe completes a byte = {db,4'h0}, with is_cmd taken from rs. If rs=0 and db[3:1]=3'b001 (DL=0), go to MODE4_HI and set mode4=1. Otherwise stay in MODE8.
  - MODE4_HI: a strobe stores db as the high nibble and rs as the byte's rs, loads the timeout counter, then goes to MODE4_LO.
  - MODE4_LO: a strobe completes byte = {hi,db}, using the rs stored with the high nibble.
    - If the current rs differs from the stored rs, set err; the byte is still emitted.
    - Next state is MODE4_HI.
    - Exception: if the byte is an instruction with byte[7:5]=3'b001 and byte[4]=1 (DL=1), go to MODE8 and clear mode4.
  - Timeout: in MODE4_LO, the counter decrements each cycle. On reaching 0 with no strobe: discard the high nibble, set err, return to MODE4_HI. A strobe in the same cycle as expiry wins.
- Byte application, in the same cycle the byte completes:
  - Instruction 8'h01 (clear) or 8'b0000001x (home): ddram_addr := 0.
  - Instruction 8'b000001ds (entry mode): I/D := d.
  - Instruction with byte[7]=1: ddram_addr := byte[6:0].
  - Data byte: ddram_addr := ddram_addr ± 1 according to I/D, modulo 128 (0x7F+1 → 0x00, 0x00−1 → 0x7F).
  - All other instructions do not change the address.
- Output register (single entry):
  - A completing byte loads bits/is_cmd at the end of the strobe cycle; val=1 from the next cycle. Latency is 1 clock after the strobe cycle.
  - val stays high until a cycle with rdy=1.
  - If a byte completes while val=1 and rdy=0: the new byte is dropped, overflow is set, and bits/is_cmd keep the old byte. ddram_addr and mode are still updated.
  - If a byte completes in a cycle where val && rdy: the new byte loads, val stays 1, no overflow.
- overflow and err clear only on rst.

Test Plan:
1. Init sequence: rs=0, three strobes with db=0x2 → bytes cmd 0x20 (mode4 goes to 1 after the first), then cmd 0x22; mode4=1, ddram_addr=0.
2. In 4-bit mode with rdy=1, rs=1 nibbles 0x4, 0x8 → val pulses 1 cycle after the second strobe, bits=0x48, is_cmd=0, ddram_addr 0→1.
3. Instruction 0xC0 → ddram_addr=0x40. Data byte → 0x41. Instruction 0x04 (I/D=0) then two data bytes → 0x3F. Instruction 0x01 → 0. Instruction 0xFF then data → address wraps 0x7F→0x00.
4. rdy=0, two data bytes 0x41, 0x42 → bits holds 0x41, overflow=1, ddram_addr advanced by 2. Raise rdy → one transfer of 0x41, then val=0.
5. High nibble with rs=1, low nibble with rs=0 → byte emitted with is_cmd=0, err=1. Separately, NIBBLE_TIMEOUT=10 with only a high nibble → err=1 after 10 clocks, and the next two nibbles form a fresh byte.
6. Strobes with rw=1 → no output. High nibble followed by rst → mode4=0, and the next strobe decodes as an 8-bit-mode byte {db,0}.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types for the HD44780-style LCD pin bundle.
//   lcd_pins_t : rw, rs, e and the upper data nibble db (DB7..DB4).
package lcd_pkg;

  typedef struct packed {
    logic       rw;
    logic       rs;
    logic       e;
    logic [3:0] db;
  } lcd_pins_t;

endpackage

// File: rtl/lcd_pin_decoder.sv
// Passive decoder for the HD44780 pin bundle. Watches e falling edges on write cycles,
// rebuilds the byte stream the panel latches (8-bit and 4-bit interface modes), tracks the
// entry-mode direction and DDRAM address, and presents each byte on a single-entry val/rdy port.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   lcd_pins     : monitored pins (rw, rs, e, db[3:0] = DB7..DB4)
//   val, rdy     : decoded byte handshake, transfer when val && rdy
//   bits, is_cmd : decoded byte and its register select (1 = instruction)
//   mode4        : decoder is in 4-bit interface mode
//   ddram_addr   : DDRAM address after the last applied byte
//   overflow     : sticky, a byte was dropped while the output was occupied
//   err          : sticky, rs changed between nibbles or the low nibble timed out
module lcd_pin_decoder
  import lcd_pkg::*;
#(
  parameter int unsigned NIBBLE_TIMEOUT = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  lcd_pins_t       lcd_pins,
  output logic            val,
  input  logic            rdy,
  output logic [7:0]      bits,
  output logic            is_cmd,
  output logic            mode4,
  output logic [6:0]      ddram_addr,
  output logic            overflow,
  output logic            err
);

  localparam int unsigned CntW = (NIBBLE_TIMEOUT > 1) ? $clog2(NIBBLE_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StMode8, StMode4Hi, StMode4Lo} state_e;

  state_e          state_q, state_d;
  logic            e_q;
  logic [3:0]      hi_q, hi_d;
  logic            hi_rs_q, hi_rs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            id_q, id_d;
  logic [6:0]      addr_q, addr_d;
  logic            val_q, val_d;
  logic [7:0]      bits_q, bits_d;
  logic            is_cmd_q, is_cmd_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic            strobe;
  logic            byte_done;
  logic [7:0]      byte_val;
  logic            byte_cmd;

  // Panel latches on the falling edge of e; read cycles never latch anything.
  assign strobe = e_q & ~lcd_pins.e & ~lcd_pins.rw;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    hi_rs_d   = hi_rs_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    addr_d    = addr_q;
    val_d     = val_q;
    bits_d    = bits_q;
    is_cmd_d  = is_cmd_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    byte_done = 1'b0;
    byte_val  = 8'h00;
    byte_cmd  = 1'b0;

    case (state_q)
      StMode8: begin
        if (strobe) begin
          byte_done = 1'b1;
          byte_val  = {lcd_pins.db, 4'h0};
          byte_cmd  = ~lcd_pins.rs;
          // Function set with DL=0 switches the panel to the 4-bit bus.
          if (!lcd_pins.rs && lcd_pins.db[3:1] == 3'b001) state_d = StMode4Hi;
        end
      end
      StMode4Hi: begin
        if (strobe) begin
          hi_d    = lcd_pins.db;
          hi_rs_d = lcd_pins.rs;
          cnt_d   = CntW'(NIBBLE_TIMEOUT);
          state_d = StMode4Lo;
        end
      end
      StMode4Lo: begin
        if (strobe) begin
          byte_done = 1'b1;
          byte_val  = {hi_q, lcd_pins.db};
          byte_cmd  = ~hi_rs_q;
          if (lcd_pins.rs != hi_rs_q) err_d = 1'b1;
          state_d = (byte_cmd && byte_val[7:4] == 4'b0011) ? StMode8 : StMode4Hi;
        end else if (NIBBLE_TIMEOUT != 0) begin
          // cnt_q == 1 is the last cycle a low nibble is still accepted.
          if (cnt_q <= CntW'(1)) begin
            err_d   = 1'b1;
            state_d = StMode4Hi;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
      default: state_d = StMode8;
    endcase

    if (byte_done) begin
      if (byte_cmd) begin
        if (byte_val[7]) begin
          addr_d = byte_val[6:0];
        end else if (byte_val[7:1] == 7'b0000001 || byte_val == 8'h01) begin
          addr_d = 7'h00;
        end else if (byte_val[7:2] == 6'b000001) begin
          id_d = byte_val[1];
        end
      end else begin
        addr_d = id_q ? addr_q + 7'd1 : addr_q - 7'd1;
      end
    end

    if (val_q && rdy) val_d = 1'b0;
    if (byte_done) begin
      if (val_q && !rdy) begin
        ovf_d = 1'b1;
      end else begin
        val_d    = 1'b1;
        bits_d   = byte_val;
        is_cmd_d = byte_cmd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StMode8;
      e_q      <= 1'b0;
      hi_q     <= 4'h0;
      hi_rs_q  <= 1'b0;
      cnt_q    <= '0;
      id_q     <= 1'b1;
      addr_q   <= 7'h00;
      val_q    <= 1'b0;
      bits_q   <= 8'h00;
      is_cmd_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= lcd_pins.e;
      hi_q     <= hi_d;
      hi_rs_q  <= hi_rs_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      val_q    <= val_d;
      bits_q   <= bits_d;
      is_cmd_q <= is_cmd_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign val        = val_q;
  assign bits       = bits_q;
  assign is_cmd     = is_cmd_q;
  assign mode4      = (state_q != StMode8);
  assign ddram_addr = addr_q;
  assign overflow   = ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lcd_pin_decoder.sv
// Bench for lcd_pin_decoder: directed sequences plus random pin traffic, every cycle compared
// against a byte-level reference model kept here.
module tb_lcd_pin_decoder;
  import lcd_pkg::*;

  localparam int unsigned Timeout = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  lcd_pins_t  pins;
  logic       val;
  logic [7:0] bits;
  logic       is_cmd;
  logic       mode4;
  logic [6:0] ddram_addr;
  logic       overflow;
  logic       err;

  always #5 clk = ~clk;

  lcd_pin_decoder #(
    .NIBBLE_TIMEOUT(Timeout)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lcd_pins  (pins),
    .val       (val),
    .rdy       (rdy),
    .bits      (bits),
    .is_cmd    (is_cmd),
    .mode4     (mode4),
    .ddram_addr(ddram_addr),
    .overflow  (overflow),
    .err       (err)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          rand_rdy = 1'b0;

  // Reference model state, kept at byte/nibble level.
  bit m_prev_e, m_mode4, m_have_hi, m_hi_rs, m_id, m_val, m_cmd, m_ovf, m_err;
  int m_hi, m_hi_cyc, m_addr, m_bits, cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit strobe, done, cmd;
    int b, age;
    strobe = m_prev_e && !pins.e && !pins.rw;
    done = 0;
    cmd  = 0;
    b    = 0;
    if (rst) begin
      m_prev_e = 0; m_mode4 = 0; m_have_hi = 0; m_hi_rs = 0; m_id = 1;
      m_val = 0; m_cmd = 0; m_ovf = 0; m_err = 0; m_hi = 0; m_addr = 0; m_bits = 0;
      cyc++;
      return;
    end
    m_prev_e = pins.e;
    if (!m_mode4) begin
      if (strobe) begin
        done = 1; b = int'(pins.db) * 16; cmd = !pins.rs;
        if (cmd && (int'(pins.db) / 2) == 1) begin
          m_mode4 = 1; m_have_hi = 0;
        end
      end
    end else if (!m_have_hi) begin
      if (strobe) begin
        m_have_hi = 1; m_hi = int'(pins.db); m_hi_rs = pins.rs; m_hi_cyc = cyc;
      end
    end else begin
      age = cyc - m_hi_cyc;
      if (strobe) begin
        done = 1; b = m_hi * 16 + int'(pins.db); cmd = !m_hi_rs;
        if (pins.rs != m_hi_rs) m_err = 1;
        m_have_hi = 0;
        if (cmd && b / 16 == 3) m_mode4 = 0;
      end else if (Timeout != 0 && age >= int'(Timeout)) begin
        m_err = 1; m_have_hi = 0;
      end
    end
    if (done) begin
      if (cmd) begin
        if (b >= 128) m_addr = b - 128;
        else if (b >= 1 && b <= 3) m_addr = 0;
        else if (b >= 4 && b <= 7) m_id = ((b / 2) % 2) == 1;
      end else begin
        m_addr = m_id ? (m_addr + 1) % 128 : (m_addr + 127) % 128;
      end
    end
    if (done) begin
      if (m_val && !rdy) m_ovf = 1;
      else begin
        m_val = 1; m_bits = b; m_cmd = cmd;
      end
    end else if (m_val && rdy) begin
      m_val = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    model_step();
    @(posedge clk);
    #1;
    check_eq("cycle", {12'h0, val, bits, is_cmd, mode4, ddram_addr, overflow, err},
             {12'h0, m_val, m_bits[7:0], m_cmd, m_mode4, m_addr[6:0], m_ovf, m_err});
  endtask

  task automatic nibble(input bit rs, input bit rw, input logic [3:0] db, input int gap);
    pins.rs = rs; pins.rw = rw; pins.db = db; pins.e = 1'b1;
    tick();
    pins.e = 1'b0;
    tick();
    repeat (gap) tick();
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    nibble(rs, 1'b0, b[7:4], 0);
    nibble(rs, 1'b0, b[3:0], 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic init4();
    nibble(1'b0, 1'b0, 4'h2, 0);
    nibble(1'b0, 1'b0, 4'h2, 0);
    nibble(1'b0, 1'b0, 4'h2, 1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pins = '0;
    cyc = 0; m_id = 1;
    do_reset();
    check_eq("reset_outs", {12'h0, val, bits, is_cmd, mode4, ddram_addr, overflow, err}, 32'h0);

    // Init: 8-bit 0x20 then 4-bit 0x22.
    nibble(1'b0, 1'b0, 4'h2, 0);
    check_eq("t1_first_byte", 32'(bits), 32'h20);
    check_eq("t1_mode4_after_first", 32'(mode4), 32'h1);
    nibble(1'b0, 1'b0, 4'h2, 0);
    nibble(1'b0, 1'b0, 4'h2, 0);
    check_eq("t1_bits", 32'(bits), 32'h22);
    check_eq("t1_is_cmd", 32'(is_cmd), 32'h1);
    check_eq("t1_addr", 32'(ddram_addr), 32'h0);
    tick();

    // Data 0x48 in 4-bit mode.
    nibble(1'b1, 1'b0, 4'h4, 0);
    nibble(1'b1, 1'b0, 4'h8, 0);
    check_eq("t2_val", 32'(val), 32'h1);
    check_eq("t2_bits", 32'(bits), 32'h48);
    check_eq("t2_is_cmd", 32'(is_cmd), 32'h0);
    check_eq("t2_addr", 32'(ddram_addr), 32'h1);
    tick();
    check_eq("t2_val_drop", 32'(val), 32'h0);

    // Address tracking.
    send_byte(1'b0, 8'hC0);
    check_eq("t3_set_addr", 32'(ddram_addr), 32'h40);
    send_byte(1'b1, 8'h55);
    check_eq("t3_inc", 32'(ddram_addr), 32'h41);
    send_byte(1'b0, 8'h04);
    send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'h55);
    check_eq("t3_dec", 32'(ddram_addr), 32'h3F);
    send_byte(1'b0, 8'h01);
    check_eq("t3_clear", 32'(ddram_addr), 32'h0);
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'hFF);
    check_eq("t3_addr_7f", 32'(ddram_addr), 32'h7F);
    send_byte(1'b1, 8'h55);
    check_eq("t3_wrap", 32'(ddram_addr), 32'h0);
    tick();

    // Overflow with rdy low.
    rdy = 1'b0;
    send_byte(1'b1, 8'h41);
    send_byte(1'b1, 8'h42);
    check_eq("t4_bits_hold", 32'(bits), 32'h41);
    check_eq("t4_overflow", 32'(overflow), 32'h1);
    check_eq("t4_addr", 32'(ddram_addr), 32'h2);
    check_eq("t4_val_held", 32'(val), 32'h1);
    rdy = 1'b1;
    tick();
    check_eq("t4_val_after", 32'(val), 32'h0);

    // rs mismatch between nibbles.
    nibble(1'b1, 1'b0, 4'h4, 0);
    nibble(1'b0, 1'b0, 4'h1, 0);
    check_eq("t5_bits", 32'(bits), 32'h41);
    check_eq("t5_is_cmd", 32'(is_cmd), 32'h0);
    check_eq("t5_err", 32'(err), 32'h1);

    // Nibble timeout.
    do_reset();
    init4();
    nibble(1'b1, 1'b0, 4'h7, 0);
    repeat (Timeout - 1) tick();
    check_eq("t5_err_before", 32'(err), 32'h0);
    tick();
    check_eq("t5_err_timeout", 32'(err), 32'h1);
    send_byte(1'b1, 8'h5A);
    check_eq("t5_fresh_byte", 32'(bits), 32'h5A);
    tick();

    // Read cycles ignored; reset mid-byte returns to 8-bit mode.
    nibble(1'b1, 1'b1, 4'hA, 0);
    nibble(1'b1, 1'b1, 4'hB, 0);
    check_eq("t6_rw_no_val", 32'(val), 32'h0);
    check_eq("t6_rw_mode4", 32'(mode4), 32'h1);
    nibble(1'b1, 1'b0, 4'h6, 0);
    do_reset();
    check_eq("t6_rst_mode4", 32'(mode4), 32'h0);
    nibble(1'b1, 1'b0, 4'h3, 0);
    check_eq("t6_mode8_byte", 32'(bits), 32'h30);
    check_eq("t6_mode8_data", 32'(is_cmd), 32'h0);

    // Random pin traffic against the model.
    rand_rdy = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      nibble($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
             4'($urandom_range(0, 15)), int'($urandom_range(0, 13)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
